// File: rtl/ifid_pipe_if.sv
// IF/ID handshake bundle: fetch-side inputs, decode-side outputs and pipeline control.
// The master drives fetch/control signals; the slave is the pipeline register itself.
interface ifid_pipe_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0] inst;
  logic                  hit;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  stall;
  logic                  out_ready;
  logic                  out_valid;
  logic [PC_WIDTH-1:0]   pcOut;
  logic [INST_WIDTH-1:0] instOut;
  logic                  hitOut;
  logic [1:0]            occupancy;

  modport master (
    output pc, inst, hit, in_valid, flush, stall, out_ready,
    input  in_ready, out_valid, pcOut, instOut, hitOut, occupancy
  );

  modport slave (
    input  pc, inst, hit, in_valid, flush, stall, out_ready,
    output in_ready, out_valid, pcOut, instOut, hitOut, occupancy
  );
endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with stall, flush-to-NOP and a 2-entry skid buffer.
// The main entry drives decode; the skid entry absorbs one word so in_ready is registered.
module ifid_pipe_reg #(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'hD503201F)
) (
  input  logic          clk,
  input  logic          rst,
  ifid_pipe_if.slave    bus
);

  logic                  r_main_valid;
  logic [PC_WIDTH-1:0]   r_main_pc;
  logic [INST_WIDTH-1:0] r_main_inst;
  logic                  r_main_hit;

  logic                  r_skid_valid;
  logic [PC_WIDTH-1:0]   r_skid_pc;
  logic [INST_WIDTH-1:0] r_skid_inst;
  logic                  r_skid_hit;

  logic                  r_in_ready;

  logic                  w_in_fire;
  logic                  w_out_take;
  logic                  w_out_fire;

  // A stall looks exactly like decode deasserting out_ready.
  assign w_out_take = bus.stall ? 1'b0 : bus.out_ready;
  assign w_out_fire = r_main_valid & w_out_take;
  assign w_in_fire  = bus.in_valid & r_in_ready;

  // Main-entry control and data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= NOP_INST;
      r_main_hit   <= 1'b0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= NOP_INST;
      r_main_hit   <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= bus.pc;
        r_main_inst  <= bus.inst;
        r_main_hit   <= bus.hit;
      end
    end else if (w_out_fire) begin
      if (r_skid_valid) begin
        r_main_pc    <= r_skid_pc;
        r_main_inst  <= r_skid_inst;
        r_main_hit   <= r_skid_hit;
      end else if (w_in_fire) begin
        r_main_pc    <= bus.pc;
        r_main_inst  <= bus.inst;
        r_main_hit   <= bus.hit;
      end else begin
        // Drained: data outputs keep showing the last word.
        r_main_valid <= 1'b0;
      end
    end
  end

  // Skid-entry valid and registered in_ready; in_ready always mirrors !skid_valid.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_main_valid && w_out_fire && r_skid_valid) begin
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_main_valid && !w_out_fire && w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  // NOTE: skid data needs no reset; it is only ever observed while r_skid_valid is set.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && r_main_valid && !w_out_fire && w_in_fire) begin
      r_skid_pc   <= bus.pc;
      r_skid_inst <= bus.inst;
      r_skid_hit  <= bus.hit;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.pcOut     = r_main_pc;
  assign bus.instOut   = r_main_inst;
  assign bus.hitOut    = r_main_hit;
  assign bus.occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Self-checking bench for ifid_pipe_reg: directed scenarios, then randomized traffic,
// all compared every cycle against a queue-based model of the stage.
module tb_ifid_pipe_reg;

  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        hit;
  } word_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  word_t q[$];
  word_t shown;

  ifid_pipe_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

  ifid_pipe_reg #(.PC_WIDTH(64), .INST_WIDTH(32), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic hit);
    bus.in_valid = v;
    bus.pc       = pc;
    bus.inst     = inst;
    bus.hit      = hit;
  endtask

  // Model: the stage is a FIFO of capacity 2 whose head is what decode sees.
  task automatic step();
    bit fi, fo;
    @(posedge clk);
    if (rst || bus.flush) begin
      q.delete();
      shown = '{pc: 64'h0, inst: NOP, hit: 1'b0};
    end else begin
      fi = bus.in_valid && (q.size() < 2);
      fo = (q.size() > 0) && !bus.stall && bus.out_ready;
      if (fo) void'(q.pop_front());
      if (fi) q.push_back('{pc: bus.pc, inst: bus.inst, hit: bus.hit});
      if (q.size() > 0) shown = q[0];
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
    chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    chk("pcOut",     bus.pcOut,          shown.pc);
    chk("instOut",   64'(bus.instOut),   64'(shown.inst));
    chk("hitOut",    64'(bus.hitOut),    64'(shown.hit));
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h99, 32'hAAAA_5555, 1'b1);
    shown = '{pc: 64'h0, inst: NOP, hit: 1'b0};

    // Reset held two cycles with the fetch offering a word.
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_instOut",   64'(bus.instOut),   64'hD503201F);
    chk("rst_pcOut",     bus.pcOut,          64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);

    // Pass-through with decode always ready.
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h0, 32'h0000_1234, 1'b1);
    step();
    chk("pt1_pc",   bus.pcOut,          64'h0);
    chk("pt1_inst", 64'(bus.instOut),   64'h1234);
    chk("pt1_hit",  64'(bus.hitOut),    64'd1);
    drive(1'b1, 64'h1111_1111_1111_1111, 32'h8765_4321, 1'b0);
    step();
    chk("pt2_pc",   bus.pcOut,          64'h1111_1111_1111_1111);
    chk("pt2_inst", 64'(bus.instOut),   64'h8765_4321);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h100 + 64'(4 * i), 32'hC000_0000 + 32'(i), i[0]);
      step();
      chk("stream_pc", bus.pcOut, 64'h100 + 64'(4 * i));
    end
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // Skid fill, then drain.
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h10, 32'hA, 1'b1);
    step();
    drive(1'b1, 64'h14, 32'hB, 1'b0);
    step();
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();
    chk("skid_occ",   64'(bus.occupancy), 64'd2);
    chk("skid_ready", 64'(bus.in_ready),  64'd0);
    chk("skid_pc",    bus.pcOut,          64'h10);
    bus.out_ready = 1'b1;
    step();
    chk("skid_pc2",    bus.pcOut,         64'h14);
    chk("skid_ready2", 64'(bus.in_ready), 64'd1);
    step();
    chk("skid_empty", 64'(bus.out_valid), 64'd0);

    // Stall with decode ready: only two words are taken.
    bus.stall = 1'b1;
    drive(1'b1, 64'h20, 32'h20, 1'b0);
    step();
    drive(1'b1, 64'h24, 32'h24, 1'b0);
    step();
    drive(1'b1, 64'h28, 32'h28, 1'b0);
    step();
    chk("stall_occ",   64'(bus.occupancy), 64'd2);
    chk("stall_ready", 64'(bus.in_ready),  64'd0);
    chk("stall_pc",    bus.pcOut,          64'h20);
    bus.stall = 1'b0;
    step();
    chk("unstall_pc1", bus.pcOut, 64'h24);
    step();
    chk("unstall_pc2", bus.pcOut, 64'h28);
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();

    // Flush a full stage while the fetch offers 0x40.
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h30, 32'h30, 1'b1);
    step();
    drive(1'b1, 64'h34, 32'h34, 1'b1);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 64'h40, 32'h40, 1'b1);
    step();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_inst",  64'(bus.instOut),   64'hD503201F);
    chk("flush_occ",   64'(bus.occupancy), 64'd0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();
    chk("flush_no40", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a full stage.
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h50, 32'h50, 1'b0);
    step();
    drive(1'b1, 64'h54, 32'h54, 1'b0);
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();
    chk("mrst_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_occ",   64'(bus.occupancy), 64'd0);
    chk("mrst_inst",  64'(bus.instOut),   64'hD503201F);
    rst = 1'b0;
    drive(1'b1, 64'h80, 32'h80, 1'b1);
    step();
    chk("mrst_pc80", bus.pcOut,          64'h80);
    chk("mrst_occ1", 64'(bus.occupancy), 64'd1);
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- Parametrised IF/ID pipeline register, the successor to the fixed 64/32-bit IFID stage.
- Carries PC, instruction and cache-hit flag from fetch to decode over a valid/ready handshake.
- Adds stall, flush with NOP bubble insertion, and a 2-entry skid buffer so in_ready is a registered signal.
- Sits between the instruction-fetch/I-cache stage and the decode stage of the pipelined ARM core.

Parameters:
- PC_WIDTH, 64, width of pc/pcOut
- INST_WIDTH, 32, width of inst/instOut
- NOP_INST, 32'hD503201F, instruction word driven on instOut after reset or flush (ARM NOP)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- pc  input  PC_WIDTH  fetch PC
- inst  input  INST_WIDTH  fetched instruction
- hit  input  1  I-cache hit flag for this fetch
- in_valid  input  1  fetch presents a valid word
- in_ready  output  1  stage can accept; registered
- flush  input  1  branch mispredict / exception kill
- stall  input  1  hazard-unit stall of decode
- out_ready  input  1  decode can accept
- out_valid  output  1  pcOut/instOut/hitOut valid
- pcOut  output  PC_WIDTH  registered PC
- instOut  output  INST_WIDTH  registered instruction
- hitOut  output  1  registered hit flag
- occupancy  output  2  entries held (0..2)

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. Each entry has a valid bit.
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_take = stall ? 0 : out_ready.
  - out_fire = out_valid & out_take.
- Reset (rst=1 at edge):
  - out_valid=0, pcOut=0, instOut=NOP_INST, hitOut=0.
  - Skid entry invalid; in_ready=1; occupancy=0.
  - Reset overrides flush and all transfers.
- Flush (rst=0, flush=1):
  - Both entries invalidated; pcOut=0, instOut=NOP_INST, hitOut=0.
  - in_ready=1 next cycle; occupancy=0.
  - An in_fire in the same cycle is dropped. An out_fire in the same cycle is still counted as consumed by decode.
- Latency: a word accepted at edge N appears on the outputs with out_valid=1 after edge N (1 cycle). Order is strictly FIFO; no word is ever duplicated or lost except by flush.
- Normal updates (rst=0, flush=0), evaluated at each edge:
  - Main empty, in_fire: main <= input.
  - Main full, out_fire, skid empty, in_fire: main <= input.
  - Main full, out_fire, skid empty, no in_fire: main invalid; data outputs hold their last values.
  - Main full, no out_fire, in_fire: skid <= input; in_ready <= 0.
  - Main full, out_fire, skid full: main <= skid; skid invalid; in_ready <= 1. No in_fire is possible because in_ready=0.
  - Main full, no out_fire, no in_fire: hold all state.
- Invariants:
  - in_ready = !skid_valid, registered.
  - Skid never accepts while full.
  - Skid is never valid while main is invalid.
  - occupancy = main_valid + skid_valid.
- Stall:
  - Identical to out_ready=0: outputs hold, and one further word may land in the skid entry.
  - stall with flush: flush wins.
- Data registers load only on a valid capture, flush or reset; otherwise they hold.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, instOut=D503201F, pcOut=0, in_ready=1, occupancy=0.
- Pass-through: out_ready=1, inject pc=0x0, inst=0x00001234, hit=1 -> one edge later out_valid=1, pcOut=0x0, instOut=0x00001234, hitOut=1. Then inject pc=0x1111111111111111, inst=0x87654321 -> next cycle the outputs show them; stream of 8 words emerges in order, 1 per cycle.
- Skid fill: out_ready=0, inject A (pc=0x10) then B (pc=0x14) -> occupancy=2, in_ready=0, pcOut=0x10 held. Raise out_ready -> pcOut=0x14 next cycle, in_ready=1 the same edge, then out_valid=0.
- Stall: stall=1 with out_ready=1 for 3 cycles while the fetch offers pc=0x20, 0x24, 0x28 -> only 0x20 and 0x24 are accepted, in_ready=0. Release -> 0x20, 0x24, 0x28 delivered in order.
- Flush: occupancy=2, assert flush with in_valid=1, pc=0x40 -> next cycle out_valid=0, instOut=D503201F, occupancy=0, 0x40 never appears.
- Reset mid-operation: occupancy=2, rst=1 for 1 cycle together with flush=0 and out_ready=1 -> reset values as in the reset test; the next accepted word (pc=0x80) appears alone.
